tdm_demux_stream: RTL and testbench
===================================

// Module: tdm_demux_stream
// PURPOSE
//  Time-division demultiplexer: the receive-side counterpart of the 2:1 select mux.
//  Takes one interleaved sample stream (ch0,ch1,..,chN-1,ch0,..) marked by frame_sync.
//  Steers each sample into a per-channel holding register with its own valid/ready port.
//  Sits between the serial TDM link and per-channel consumers; detects frame misalignment.
// PARAMETERS
//  WIDTH   8   bits per sample
//  NCH     2   channels per frame (>=2); CNT_W = $clog2(NCH)
//  FCNT_W  8   width of the completed-frame counter
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rst_n        in   1           asynchronous assert, active-low reset
//  din          in   WIDTH       interleaved sample
//  din_valid    in   1           sample present on din
//  frame_sync   in   1           qualifies din as channel 0 of a frame (sampled only with din_valid)
//  din_ready    out  1           stream accepts din this cycle
//  dout         out  NCH*WIDTH   channel k data at [k*WIDTH +: WIDTH]
//  dout_valid   out  NCH         channel k holding register full
//  dout_ready   in   NCH         channel k consumer takes data
//  locked       out  1           FSM in LOCKED
//  sync_err     out  1           1-cycle pulse on frame misalignment
//  frame_cnt    out  FCNT_W      completed frames, wraps 2^FCNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HUNT, chan_cnt=0, dout=0, dout_valid=0, sync_err=0,
//   frame_cnt=0, locked=0. Reset mid-frame discards all held samples; no partial output.
//  Accept = din_valid & din_ready. Accepted sample appears on dout/dout_valid next cycle (latency 1).
//  HUNT: din_ready = !dout_valid[0] | dout_ready[0]. Accept without frame_sync -> dropped.
//   Accept with frame_sync -> write ch0, chan_cnt<=1, go LOCKED.
//  LOCKED: target = chan_cnt; din_ready = !dout_valid[target] | dout_ready[target]
//   (combinational ready pass-through; a full channel back-pressures the whole stream).
//   - frame_sync=1 & chan_cnt==0: normal, write ch0, chan_cnt<=1.
//   - frame_sync=0 & chan_cnt!=0: normal, write ch[chan_cnt], chan_cnt<=chan_cnt+1;
//     chan_cnt==NCH-1 wraps to 0 and frame_cnt increments.
//   - frame_sync=1 & chan_cnt!=0 (early sync): sync_err pulse, sample written to ch0
//     (target forced to 0, ready evaluated on ch0), chan_cnt<=1, stay LOCKED; frame_cnt unchanged.
//   - frame_sync=0 & chan_cnt==0 (missing sync): sync_err pulse, sample dropped
//     (din_ready=1 this cycle), chan_cnt<=0, go HUNT.
//  Holding reg k: valid set on write, cleared on dout_ready[k] & dout_valid[k];
//   simultaneous drain+write -> stays valid with new data. dout holds value while valid & !ready.
//  No accept when din_valid=0: no state change. frame_sync ignored without din_valid.
//  locked is registered state (=1 iff LOCKED). sync_err registered, high exactly one cycle per event.
// STRUCTURE
//  Package tdm_pkg: state enum {HUNT, LOCKED}; CNT_W derivation function; default WIDTH/NCH.
//  Sub-module tdm_chan_reg (one WIDTH-bit valid/ready holding register), generated NCH times.
//  Top holds FSM, chan_cnt, frame_cnt, target decode and ready mux.
// TESTING
//  1 Reset, feed 0xA1(sync),0xB2 with all ready=1 -> HUNT->LOCKED; ch0=0xA1, ch1=0xB2 a cycle after each; frame_cnt=1.
//  2 Unsynced 0x11,0x22 then 0x33(sync) -> first two dropped, din_ready=1; ch0=0x33, locked=1.
//  3 Locked, dout_ready[1]=0, ch1 full, next frame ch1 sample -> din_ready=0, stall until ready[1]=1; no data loss.
//  4 NCH=4, sync on 3rd sample -> sync_err one cycle, sample in ch0, chan_cnt=1, locked stays 1.
//  5 Locked, chan_cnt wrapped to 0, sample without sync -> sync_err, dropped, locked=0; next sync relocks.
//  6 rst_n low mid-frame with dout_valid=2'b01 -> dout_valid=0, frame_cnt=0 immediately (async); 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM receive-side demultiplexer.
//  - default sample width, channel count and frame-counter width
//  - receive FSM state encoding
//  - channel-counter width helper
package tdm_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NCH    = 2;
  localparam int DEF_FCNT_W = 8;

  // HUNT waits for a frame_sync sample; LOCKED tracks the channel position.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of the channel counter. The lower bound of 1 keeps the counter
  // non-empty even for a degenerate channel count.
  function automatic int calc_cnt_w(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/tdm_demux_stream_if.sv
// tdm_demux_stream_if: stream bundle for the TDM demultiplexer.
//  din/din_valid/frame_sync/din_ready : interleaved input stream
//  dout/dout_valid/dout_ready         : NCH per-channel output ports,
//                                       channel k at dout[k*WIDTH +: WIDTH]
//  master = traffic source/sink around the block, slave = the demultiplexer.
interface tdm_demux_stream_if import tdm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) ();

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic                 din_ready;
  logic [NCH*WIDTH-1:0] dout;
  logic [NCH-1:0]       dout_valid;
  logic [NCH-1:0]       dout_ready;

  modport master (
    output din, din_valid, frame_sync, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, frame_sync, dout_ready,
    output din_ready, dout, dout_valid
  );

endinterface

// File: rtl/tdm_chan_reg.sv
// tdm_chan_reg: one-entry valid/ready holding register for a single channel.
//  clk, rst_n : clock, asynchronous active-low reset
//  wr_en      : load wr_data this cycle
//  wr_data    : sample to hold
//  rd_ready   : consumer takes the held sample
//  data       : held sample (stable while valid and not taken)
//  valid      : register full
module tdm_chan_reg import tdm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // A write wins over a drain, so a simultaneous drain+write keeps the
  // register full with the new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (valid && rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux_stream.sv
// tdm_demux_stream: time-division demultiplexer. Splits one interleaved
// stream (ch0, ch1, .., chN-1, ch0, ..) marked by frame_sync into NCH
// per-channel holding registers and detects frame misalignment.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : stream bundle (slave side), see tdm_demux_stream_if
//  locked     : receiver is aligned to the frame
//  sync_err   : one-cycle pulse per misalignment event
//  frame_cnt  : completed frames, wraps to 0
module tdm_demux_stream import tdm_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NCH    = DEF_NCH,
  parameter int FCNT_W = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_stream_if.slave bus,
  output logic              locked,
  output logic              sync_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int               CNT_W   = calc_cnt_w(NCH);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NCH - 1);

  state_t           state;
  logic [CNT_W-1:0] chan_cnt;
  logic [CNT_W-1:0] target;
  logic [NCH-1:0]   ch_valid;
  logic [NCH-1:0]   wr_en;
  logic             missing_sync;
  logic             accept;
  logic             write;

  // Target decode and ready mux. A sync sample always lands in ch0, so an
  // early sync re-targets ch0 and takes its readiness from there. A missing
  // sync drops the sample, so it is accepted unconditionally.
  always_comb begin
    target        = '0;
    missing_sync  = (state == LOCKED) && !bus.frame_sync && (chan_cnt == '0);
    if ((state == LOCKED) && !bus.frame_sync) begin
      target = chan_cnt;
    end
    if (missing_sync) begin
      bus.din_ready = 1'b1;
    end else begin
      bus.din_ready = !ch_valid[target] || bus.dout_ready[target];
    end
    accept = bus.din_valid && bus.din_ready;
    write  = accept && !missing_sync && ((state == LOCKED) || bus.frame_sync);
    wr_en  = '0;
    if (write) begin
      wr_en[target] = 1'b1;
    end
  end

  // Frame alignment FSM, channel position and completed-frame counter.
  // Nothing moves unless a sample is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      chan_cnt  <= '0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sync_err <= 1'b0;
      if (accept) begin
        if (state == HUNT) begin
          if (bus.frame_sync) begin
            state    <= LOCKED;
            chan_cnt <= CNT_W'(1);
          end
        end else if (bus.frame_sync) begin
          sync_err <= (chan_cnt != '0);
          chan_cnt <= CNT_W'(1);
        end else if (chan_cnt == '0) begin
          sync_err <= 1'b1;
          state    <= HUNT;
          chan_cnt <= '0;
        end else if (chan_cnt == LAST_CH) begin
          chan_cnt  <= '0;
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end else begin
          chan_cnt <= chan_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign locked = (state == LOCKED);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    tdm_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (bus.din),
      .rd_ready(bus.dout_ready[k]),
      .data    (bus.dout[k*WIDTH +: WIDTH]),
      .valid   (ch_valid[k])
    );
  end

  assign bus.dout_valid = ch_valid;

endmodule

// File: tb/tb_tdm_demux_stream.sv
// tb_tdm_demux_stream: self-checking bench for tdm_demux_stream.
// Two instances (NCH=2 and NCH=4) receive the same stimulus. A behavioural
// model per instance predicts din_ready, locked, sync_err, frame_cnt and
// dout_valid; samples written to a channel are queued and compared when the
// consumer drains that channel.
module tb_tdm_demux_stream;
  import tdm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] rdy = 4'hF;

  logic       locked0, locked1, err0, err1;
  logic [7:0] fc0, fc1;

  int check_cnt = 0;
  int err_cnt   = 0;

  // model state, index 0 = NCH=2 instance, 1 = NCH=4 instance
  int         nch [2] = '{2, 4};
  logic       m_lock [2];
  int         m_cnt [2];
  logic [7:0] m_fc [2];
  logic       m_err [2];
  logic       m_val [2][4];
  logic [7:0] exp_q [2][4][$];

  tdm_demux_stream_if #(.WIDTH(8), .NCH(2)) if0 ();
  tdm_demux_stream_if #(.WIDTH(8), .NCH(4)) if1 ();

  assign if0.din        = din;
  assign if0.din_valid  = din_valid;
  assign if0.frame_sync = frame_sync;
  assign if0.dout_ready = rdy[1:0];
  assign if1.din        = din;
  assign if1.din_valid  = din_valid;
  assign if1.frame_sync = frame_sync;
  assign if1.dout_ready = rdy;

  tdm_demux_stream #(.WIDTH(8), .NCH(2), .FCNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .locked(locked0), .sync_err(err0), .frame_cnt(fc0)
  );

  tdm_demux_stream #(.WIDTH(8), .NCH(4), .FCNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .locked(locked1), .sync_err(err1), .frame_cnt(fc1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic exp_ready(input int i);
    int tgt;
    if (!m_lock[i]) return !m_val[i][0] || rdy[0];
    if (!frame_sync && m_cnt[i] == 0) return 1'b1;
    tgt = frame_sync ? 0 : m_cnt[i];
    return !m_val[i][tgt] || rdy[tgt];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lock[i] = 1'b0;
      m_cnt[i]  = 0;
      m_fc[i]   = '0;
      m_err[i]  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_val[i][k] = 1'b0;
        exp_q[i][k].delete();
      end
    end
  endtask

  task automatic model_write(input int i, input int k);
    m_val[i][k] = 1'b1;
    exp_q[i][k].push_back(din);
  endtask

  // advance one instance's model across the coming rising edge
  task automatic step_model(input int i);
    logic acc;
    acc = din_valid && exp_ready(i);
    m_err[i] = 1'b0;
    for (int k = 0; k < nch[i]; k++) begin
      if (m_val[i][k] && rdy[k]) m_val[i][k] = 1'b0;
    end
    if (acc) begin
      if (!m_lock[i]) begin
        if (frame_sync) begin
          model_write(i, 0);
          m_cnt[i]  = 1;
          m_lock[i] = 1'b1;
        end
      end else if (frame_sync) begin
        if (m_cnt[i] != 0) m_err[i] = 1'b1;
        model_write(i, 0);
        m_cnt[i] = 1;
      end else if (m_cnt[i] == 0) begin
        m_err[i]  = 1'b1;
        m_lock[i] = 1'b0;
      end else begin
        model_write(i, m_cnt[i]);
        if (m_cnt[i] == nch[i] - 1) begin
          m_cnt[i] = 0;
          m_fc[i]  = m_fc[i] + 8'd1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic check_instance(input int i, input logic a_rdy, input logic a_lock,
                                input logic a_err, input logic [7:0] a_fc,
                                input logic [3:0] a_vld, input logic [31:0] a_dout);
    logic [7:0] exp_d;
    check_output($sformatf("i%0d.din_ready", i), 32'(a_rdy), 32'(exp_ready(i)));
    check_output($sformatf("i%0d.locked", i), 32'(a_lock), 32'(m_lock[i]));
    check_output($sformatf("i%0d.sync_err", i), 32'(a_err), 32'(m_err[i]));
    check_output($sformatf("i%0d.frame_cnt", i), 32'(a_fc), 32'(m_fc[i]));
    for (int k = 0; k < nch[i]; k++) begin
      check_output($sformatf("i%0d.dout_valid[%0d]", i, k), 32'(a_vld[k]), 32'(m_val[i][k]));
      if (m_val[i][k] && rdy[k]) begin
        exp_d = exp_q[i][k].pop_front();
        check_output($sformatf("i%0d.dout[%0d]", i, k), 32'(a_dout[k*8 +: 8]), 32'(exp_d));
      end
    end
  endtask

  // drive one cycle of stimulus, compare against the model, then advance it
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic fs, input logic [3:0] r);
    @(negedge clk);
    din_valid  = v;
    din        = d;
    frame_sync = fs;
    rdy        = r;
    #1;
    check_instance(0, if0.din_ready, locked0, err0, fc0, {2'b00, if0.dout_valid}, {16'h0, if0.dout});
    check_instance(1, if1.din_ready, locked1, err1, fc1, if1.dout_valid, if1.dout);
    step_model(0);
    step_model(1);
  endtask

  task automatic idle(input int n, input logic [3:0] r);
    for (int c = 0; c < n; c++) apply_stimulus(1'b0, 8'h00, 1'b0, r);
  endtask

  // asynchronous reset asserted between clock edges; outputs must clear at once
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    #1;
    check_output({tag, ".vld0"}, 32'(if0.dout_valid), 32'h0);
    check_output({tag, ".vld1"}, 32'(if1.dout_valid), 32'h0);
    check_output({tag, ".fc0"}, 32'(fc0), 32'h0);
    check_output({tag, ".lock0"}, 32'(locked0), 32'h0);
    check_output({tag, ".err1"}, 32'(err1), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #22;
    check_output("rst.lock0", 32'(locked0), 32'h0);
    check_output("rst.lock1", 32'(locked1), 32'h0);
    check_output("rst.fc1", 32'(fc1), 32'h0);
    check_output("rst.vld0", 32'(if0.dout_valid), 32'h0);
    check_output("rst.dout1", if1.dout, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: clean frame locks and fills both channels
    apply_stimulus(1'b1, 8'hA1, 1'b1, 4'hF);
    apply_stimulus(1'b1, 8'hB2, 1'b0, 4'hF);
    idle(2, 4'hF);
    check_output("t1.lock0", 32'(locked0), 32'h1);
    check_output("t1.fc0", 32'(fc0), 32'h1);

    // 2: unsynced samples dropped while hunting
    do_reset("t2");
    apply_stimulus(1'b1, 8'h11, 1'b0, 4'hF);
    apply_stimulus(1'b1, 8'h22, 1'b0, 4'hF);
    check_output("t2.ready", 32'(if0.din_ready), 32'h1);
    apply_stimulus(1'b1, 8'h33, 1'b1, 4'hF);
    idle(2, 4'hF);
    check_output("t2.lock0", 32'(locked0), 32'h1);

    // 3: a full ch1 back-pressures the stream without losing data
    do_reset("t3");
    apply_stimulus(1'b1, 8'hA0, 1'b1, 4'hF);
    apply_stimulus(1'b1, 8'hA1, 1'b0, 4'hF);
    apply_stimulus(1'b1, 8'hA2, 1'b1, 4'b1101);
    apply_stimulus(1'b1, 8'hA3, 1'b0, 4'b1101);
    apply_stimulus(1'b1, 8'hA4, 1'b1, 4'b1101);
    for (int c = 0; c < 3; c++) apply_stimulus(1'b1, 8'hA5, 1'b0, 4'b1101);
    check_output("t3.stall", 32'(if0.din_ready), 32'h0);
    apply_stimulus(1'b1, 8'hA5, 1'b0, 4'hF);
    idle(2, 4'hF);

    // 4: early sync on the 4-channel instance
    do_reset("t4");
    apply_stimulus(1'b1, 8'h41, 1'b1, 4'hF);
    apply_stimulus(1'b1, 8'h42, 1'b0, 4'hF);
    apply_stimulus(1'b1, 8'h43, 1'b1, 4'hF);
    idle(1, 4'hF);
    check_output("t4.err1", 32'(err1), 32'h1);
    check_output("t4.lock1", 32'(locked1), 32'h1);
    idle(1, 4'hF);
    check_output("t4.err1_clr", 32'(err1), 32'h0);
    apply_stimulus(1'b1, 8'h44, 1'b0, 4'hF);
    idle(2, 4'hF);

    // 5: missing sync drops the sample and returns to hunting
    do_reset("t5");
    apply_stimulus(1'b1, 8'h51, 1'b1, 4'hF);
    apply_stimulus(1'b1, 8'h52, 1'b0, 4'hF);
    apply_stimulus(1'b1, 8'h53, 1'b0, 4'hF);
    idle(1, 4'hF);
    check_output("t5.err0", 32'(err0), 32'h1);
    check_output("t5.lock0", 32'(locked0), 32'h0);
    apply_stimulus(1'b1, 8'h54, 1'b1, 4'hF);
    idle(2, 4'hF);

    // 6: reset mid-frame with ch0 held, then frame counter wrap
    do_reset("t6a");
    apply_stimulus(1'b1, 8'h61, 1'b1, 4'b1110);
    idle(1, 4'b1110);
    check_output("t6.held", 32'(if0.dout_valid), 32'h1);
    do_reset("t6b");
    for (int f = 0; f < 256; f++) begin
      apply_stimulus(1'b1, 8'(f), 1'b1, 4'hF);
      apply_stimulus(1'b1, 8'(~f), 1'b0, 4'hF);
      if (f == 254) begin
        idle(1, 4'hF);
        check_output("t6.fc255", 32'(fc0), 32'd255);
      end
    end
    idle(2, 4'hF);
    check_output("t6.wrap", 32'(fc0), 32'h0);

    // random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                     4'($urandom));
    end
    idle(3, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
